tri_scheduler: RTL and testbench

TRI_SCHEDULER -- requirements
Module: tri_scheduler

---
 rtl/raster_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/tri_scheduler.sv | 132 +++++++++++++
 tb/tb_tri_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
// raster_pkg : shared triangle widths, scheduler FSM encoding, default watchdog
// Revision   : 1.0
// ============================================================================
package raster_pkg;

  localparam int FIELD_BITS = 16;
  localparam int TRI_BITS   = 9 * FIELD_BITS;

  localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd1000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin arbiter with a single priority pointer
// Revision    : 1.0
// ============================================================================
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // Index of the requester that wins when both are requesting.
  logic r_ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After a grant, priority passes to the requester that did not win.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr <= 1'b0;
    end else if (update) begin
      r_ptr <= grant[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tri_scheduler.sv
`default_nettype none
// ============================================================================
// tri_scheduler : arbitrates two triangle sources, serializes one triangle at a
//                 time to the rasterizer and retires it on done or watchdog
// Revision      : 1.0
// ============================================================================
module tri_scheduler
  import raster_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ0_VALID,
  input  logic [TRI_BITS-1:0] REQ0_TRI,
  output logic                REQ0_READY,
  input  logic                REQ1_VALID,
  input  logic [TRI_BITS-1:0] REQ1_TRI,
  output logic                REQ1_READY,
  output logic                R_START,
  output logic                R_D,
  input  logic                R_DONE,
  output logic                R_FLUSH,
  output logic                BUSY,
  output logic                TRI_DONE,
  output logic                TRI_ID,
  output logic                TIMEOUT_ERR
);

  localparam logic [7:0]  c_last_bit  = 8'(TRI_BITS - 1);
  localparam logic [23:0] c_wdog_last = TIMEOUT_CYCLES - 24'd1;

  sched_state_e        r_state;
  sched_state_e        w_next_state;
  logic [TRI_BITS-1:0] r_shift;
  logic [7:0]          r_bit_cnt;
  logic [23:0]         r_wdog;
  logic                r_tri_id;
  logic                r_timeout;
  logic [1:0]          w_grant;
  logic                w_xfer;
  logic                w_expired;

  assign w_xfer    = (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_expired = (r_wdog == c_wdog_last);
  assign TRI_ID    = r_tri_id;

  rr_arbiter2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    ({REQ1_VALID, REQ0_VALID}),
    .update (w_xfer),
    .grant  (w_grant)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    REQ0_READY   = 1'b0;
    REQ1_READY   = 1'b0;
    R_START      = 1'b0;
    R_D          = 1'b0;
    R_FLUSH      = 1'b0;
    TRI_DONE     = 1'b0;
    TIMEOUT_ERR  = 1'b0;
    BUSY         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        REQ0_READY = w_grant[0];
        REQ1_READY = w_grant[1];
        if (w_xfer) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        R_START = 1'b1;
        R_D     = r_shift[TRI_BITS-1];
        if (r_bit_cnt == c_last_bit) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle takes precedence over the timeout.
        if (R_DONE || w_expired) w_next_state = ST_RETIRE;
      end
      ST_RETIRE: begin
        TRI_DONE     = 1'b1;
        TIMEOUT_ERR  = r_timeout;
        R_FLUSH      = r_timeout;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_bit_cnt <= 8'd0;
      r_wdog    <= 24'd0;
      r_tri_id  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_shift   <= w_grant[1] ? REQ1_TRI : REQ0_TRI;
            r_tri_id  <= w_grant[1];
            r_bit_cnt <= 8'd0;
            r_timeout <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_shift   <= {r_shift[TRI_BITS-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 8'd1;
          if (r_bit_cnt == c_last_bit) r_wdog <= 24'd0;
        end
        ST_WAIT: begin
          r_wdog    <= r_wdog + 24'd1;
          r_timeout <= w_expired && !R_DONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tri_scheduler : scoreboard bench for tri_scheduler (serial frames, grants,
//                    retire timing, watchdog, reset abandonment)
// Revision         : 1.0
// ============================================================================
module tb_tri_scheduler;

  localparam logic [23:0]  TB_TIMEOUT = 24'd16;
  localparam logic [143:0] PAT0  = 144'h0040_0080_FFFF_00C0_0100_8001_0140_0180_7FFE;
  localparam logic [143:0] PAT_A = 144'hA5A5_0001_1234_5678_9ABC_DEF0_8000_0003_C3C3;
  localparam logic [143:0] PAT_B = 144'h5A5A_FFFE_EDCB_A987_6543_210F_7FFF_FFFC_3C3C;
  localparam logic [143:0] PAT_C = 144'hF0F0_0F0F_AAAA_5555_CCCC_3333_1111_EEEE_0101;
  localparam logic [143:0] PAT_D = 144'h8001_4002_2004_1008_0810_0420_0240_0180_FFFF;

  typedef struct {
    logic id;
    int   lat;
    logic to;
  } done_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ0_VALID, REQ1_VALID;
  logic [143:0] REQ0_TRI, REQ1_TRI;
  logic         REQ0_READY, REQ1_READY;
  logic         R_START, R_D, R_DONE, R_FLUSH, BUSY, TRI_DONE, TRI_ID, TIMEOUT_ERR;
  logic         rdone_auto = 1'b0;
  logic         rdone_man  = 1'b0;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           mon_cnt = 0;
  logic [143:0] mon_bits = '0;
  logic [143:0] exp_tri_q[$];
  done_t        exp_done_q[$];
  int           grant_log[$];
  logic         mdl_idle = 1'b1;
  logic         mdl_ptr = 1'b0;
  logic         wait_active = 1'b0;
  int           wait_start = 0;
  int           acc_cyc = 0;
  int           rd_delay = -1;

  assign R_DONE = rdone_auto | rdone_man;

  always #5 CLK = ~CLK;

  tri_scheduler #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ0_VALID  (REQ0_VALID),
    .REQ0_TRI    (REQ0_TRI),
    .REQ0_READY  (REQ0_READY),
    .REQ1_VALID  (REQ1_VALID),
    .REQ1_TRI    (REQ1_TRI),
    .REQ1_READY  (REQ1_READY),
    .R_START     (R_START),
    .R_D         (R_D),
    .R_DONE      (R_DONE),
    .R_FLUSH     (R_FLUSH),
    .BUSY        (BUSY),
    .TRI_DONE    (TRI_DONE),
    .TRI_ID      (TRI_ID),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  task automatic check_val(input string tag, input logic [143:0] obs, input logic [143:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] mdl_grant(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Monitor, reference model and rasterizer responder, all sampled mid-cycle.
  always @(negedge CLK) begin
    logic [1:0] g;
    done_t      d;
    cyc++;
    if (RST) begin
      exp_tri_q.delete();
      exp_done_q.delete();
      mon_cnt     = 0;
      mdl_idle    = 1'b1;
      mdl_ptr     = 1'b0;
      wait_active = 1'b0;
      rdone_auto  = 1'b0;
    end else begin
      g = mdl_grant({REQ1_VALID, REQ0_VALID}, mdl_ptr);
      check_val("ready", 144'({REQ1_READY, REQ0_READY}), 144'(mdl_idle ? g : 2'b00));
      check_val("busy", 144'(BUSY), 144'(!mdl_idle));
      if (R_D && !R_START) check_val("rd_outside_shift", 144'(R_D), 144'(0));

      if (R_START) begin
        if (mon_cnt == 0) check_val("start_latency", 144'(cyc - acc_cyc), 144'(1));
        mon_bits = {mon_bits[142:0], R_D};
        mon_cnt++;
      end else if (mon_cnt != 0) begin
        if (exp_tri_q.size() == 0) begin
          check_val("frame_unexpected", 144'(mon_cnt), 144'(0));
        end else begin
          check_val("frame_len", 144'(mon_cnt), 144'(144));
          check_val("frame_data", mon_bits, exp_tri_q.pop_front());
        end
        mon_cnt     = 0;
        wait_active = 1'b1;
        wait_start  = cyc;
      end

      if (TRI_DONE) begin
        if (exp_done_q.size() == 0) begin
          check_val("done_unexpected", 144'(TRI_DONE), 144'(0));
        end else begin
          d = exp_done_q.pop_front();
          check_val("tri_id", 144'(TRI_ID), 144'(d.id));
          check_val("timeout_err", 144'(TIMEOUT_ERR), 144'(d.to));
          check_val("r_flush", 144'(R_FLUSH), 144'(d.to));
          check_val("retire_latency", 144'(cyc - wait_start), 144'(d.lat));
        end
        wait_active = 1'b0;
      end else if (TIMEOUT_ERR || R_FLUSH) begin
        check_val("orphan_pulse", 144'({TIMEOUT_ERR, R_FLUSH}), 144'(0));
      end

      if (mdl_idle && g != 2'b00) begin
        exp_tri_q.push_back(g[1] ? REQ1_TRI : REQ0_TRI);
        d.id = g[1];
        if (rd_delay >= 0 && rd_delay < int'(TB_TIMEOUT)) begin
          d.lat = rd_delay + 1;
          d.to  = 1'b0;
        end else begin
          d.lat = int'(TB_TIMEOUT);
          d.to  = 1'b1;
        end
        exp_done_q.push_back(d);
        grant_log.push_back(int'(g[1]));
        acc_cyc  = cyc;
        mdl_ptr  = ~g[1];
        mdl_idle = 1'b0;
      end else if (TRI_DONE) begin
        mdl_idle = 1'b1;
      end

      rdone_auto = wait_active && rd_delay >= 0 && (cyc - wait_start) == rd_delay;
    end
  end

  task automatic pulse_req(input logic n, input logic [143:0] pat);
    @(posedge CLK); #1;
    if (n) begin REQ1_TRI = pat; REQ1_VALID = 1'b1; end
    else   begin REQ0_TRI = pat; REQ0_VALID = 1'b1; end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    REQ0_TRI   = ~pat;
    REQ1_TRI   = {pat[71:0], pat[143:72]};
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (exp_tri_q.size() == 0 && exp_done_q.size() == 0) break;
      @(posedge CLK);
    end
    #1;
    check_val(tag, 144'(exp_tri_q.size() + exp_done_q.size()), 144'(0));
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (mon_cnt == n) break;
    end
    check_val("reach_bit", 144'(mon_cnt), 144'(n));
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    grant_log.delete();
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed cycle %0d, expected finish", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    RST = 1'b1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    REQ0_TRI = '0;     REQ1_TRI = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_r_start", 144'(R_START), 144'(0));
    check_val("rst_r_d", 144'(R_D), 144'(0));
    check_val("rst_r_flush", 144'(R_FLUSH), 144'(0));
    check_val("rst_tri_done", 144'(TRI_DONE), 144'(0));
    check_val("rst_timeout_err", 144'(TIMEOUT_ERR), 144'(0));
    check_val("rst_busy", 144'(BUSY), 144'(0));
    check_val("rst_tri_id", 144'(TRI_ID), 144'(0));
    check_val("rst_ready", 144'({REQ1_READY, REQ0_READY}), 144'(0));

    // Single one-cycle request in the very first cycle out of reset.
    rd_delay   = 3;
    REQ0_TRI   = PAT0;
    REQ0_VALID = 1'b1;
    RST        = 1'b0;
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    REQ0_TRI   = ~PAT0;
    drain("drain_single");

    // Both requesters held valid: grants must alternate from requester 0.
    pulse_reset();
    rd_delay   = 5;
    REQ0_TRI   = PAT_A;
    REQ1_TRI   = PAT_B;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      if (grant_log.size() >= 4) break;
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    drain("drain_rr");
    check_val("grant_count", 144'(grant_log.size()), 144'(4));
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      check_val($sformatf("grant_%0d", k), 144'(grant_log[k]), 144'(k % 2));

    // Watchdog expiry with no done.
    rd_delay = -1;
    pulse_req(1'b1, PAT_C);
    drain("drain_timeout");

    // Done on the exact expiry cycle.
    rd_delay = int'(TB_TIMEOUT) - 1;
    pulse_req(1'b0, PAT_D);
    drain("drain_tie");

    // Reset in the middle of serialization, then a full triangle.
    rd_delay = 2;
    pulse_req(1'b0, PAT_C);
    wait_bits(70);
    RST = 1'b1;
    #1;
    check_val("abort_r_start", 144'(R_START), 144'(0));
    check_val("abort_busy", 144'(BUSY), 144'(0));
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    pulse_req(1'b1, PAT_D);
    drain("drain_after_abort");

    // Stray done pulses in IDLE and during SHIFT.
    rd_delay = 4;
    @(posedge CLK); #1;
    rdone_man = 1'b1;
    @(posedge CLK); #1;
    rdone_man = 1'b0;
    pulse_req(1'b0, PAT_B);
    wait_bits(50);
    rdone_man = 1'b1;
    @(posedge CLK); #1;
    rdone_man = 1'b0;
    drain("drain_stray_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
